// File: rtl/clock_div_pkg.sv
// Shared types and sizing helpers for the multi-channel clock/tick divider.
package clock_div_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  // Channel config word layout, MSB first: {en, mode, div[WIDTH-1:0]}
  localparam int CFG_CTRL_W = 2;

  function automatic int ch_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  function automatic int cfg_w(input int width);
    return width + CFG_CTRL_W;
  endfunction

endpackage

// File: rtl/clock_div_ch.sv
// One divider channel: config registers, terminal counter and registered clk/tick outputs.
module clock_div_ch
  import clock_div_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter int unsigned DEFAULT_DIV  = 100000,
  parameter bit          DEFAULT_MODE = 1'b0,
  parameter bit          RESET_EN     = 1'b1
) (
  input  logic                     iClk,
  input  logic                     nRst,
  input  logic                     load_i,
  input  logic                     sync_i,
  input  logic [cfg_w(WIDTH)-1:0]  cfg_i,
  output logic                     clk_o,
  output logic                     tick_o,
  output logic                     active_o
);

  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d;
  logic             en_q, en_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic             cfg_en_s;
  logic             cfg_mode_s;
  logic [WIDTH-1:0] cfg_div_s;
  logic             active_s;
  logic             term_s;

  assign {cfg_en_s, cfg_mode_s, cfg_div_s} = cfg_i;

  // div != 0 is part of the active test, so div - 1 never underflows when it matters
  assign active_s = en_q && (div_q != {WIDTH{1'b0}});
  assign term_s   = (cnt_q == (div_q - WIDTH'(1)));

  // Next-state: load beats sync beats idle beats counting
  always_comb begin
    div_d  = div_q;
    mode_d = mode_q;
    en_d   = en_q;
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = tick_q;
    if (load_i) begin
      div_d  = cfg_div_s;
      mode_d = mode_e'(cfg_mode_s);
      en_d   = cfg_en_s;
      cnt_d  = {WIDTH{1'b0}};
      clk_d  = 1'b0;
      tick_d = 1'b0;
    end else if (sync_i || !active_s) begin
      cnt_d  = {WIDTH{1'b0}};
      clk_d  = 1'b0;
      tick_d = 1'b0;
    end else if (term_s) begin
      cnt_d  = {WIDTH{1'b0}};
      tick_d = 1'b1;
      if (mode_q == MODE_TOGGLE) begin
        clk_d = ~clk_q;
      end else begin
        clk_d = 1'b1;
      end
    end else begin
      cnt_d  = cnt_q + WIDTH'(1);
      tick_d = 1'b0;
      if (mode_q == MODE_TOGGLE) begin
        clk_d = clk_q;
      end else begin
        clk_d = 1'b0;
      end
    end
  end

  // Config, counter and output registers
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      div_q  <= WIDTH'(DEFAULT_DIV);
      mode_q <= mode_e'(DEFAULT_MODE);
      en_q   <= RESET_EN;
      cnt_q  <= {WIDTH{1'b0}};
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      mode_q <= mode_d;
      en_q   <= en_d;
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_o    = clk_q;
  assign tick_o   = tick_q;
  assign active_o = active_s;

endmodule

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock/tick divider with a global phase-restart input.
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          WIDTH        = 32,
  parameter int unsigned DEFAULT_DIV  = 100000,
  parameter bit          DEFAULT_MODE = 1'b0,
  parameter bit          RESET_EN     = 1'b1,
  localparam int         CH_W         = ch_w(NUM_CH)
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              iWr,
  input  logic [CH_W-1:0]   iWrCh,
  input  logic [WIDTH-1:0]  iWrDiv,
  input  logic              iWrMode,
  input  logic              iWrEn,
  input  logic              iSync,
  output logic [NUM_CH-1:0] oClk,
  output logic [NUM_CH-1:0] oTick,
  output logic [NUM_CH-1:0] oActive
);

  logic [cfg_w(WIDTH)-1:0] wr_cfg_s;
  logic [NUM_CH-1:0]       load_s;

  assign wr_cfg_s = {iWrEn, iWrMode, iWrDiv};

  // Indices at or above NUM_CH match no channel and are dropped
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load_s[i] = iWr && (iWrCh == CH_W'(i));

    clock_div_ch #(
      .WIDTH        (WIDTH),
      .DEFAULT_DIV  (DEFAULT_DIV),
      .DEFAULT_MODE (DEFAULT_MODE),
      .RESET_EN     (RESET_EN)
    ) u_ch (
      .iClk     (iClk),
      .nRst     (nRst),
      .load_i   (load_s[i]),
      .sync_i   (iSync),
      .cfg_i    (wr_cfg_s),
      .clk_o    (oClk[i]),
      .tick_o   (oTick[i]),
      .active_o (oActive[i])
    );
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed self-checking bench for clock_div_multi (3 channels, 8-bit divisors, reset div 4).
module tb_clock_div_multi;

  logic       iClk = 1'b0;
  logic       nRst = 1'b0;
  logic       iWr = 1'b0;
  logic [1:0] iWrCh = 2'd0;
  logic [7:0] iWrDiv = 8'd0;
  logic       iWrMode = 1'b0;
  logic       iWrEn = 1'b0;
  logic       iSync = 1'b0;
  logic [2:0] oClk, oTick, oActive;

  int n_checks = 0;
  int n_err = 0;
  int last_rise, rises;
  logic prev_clk, cur_clk;

  clock_div_multi #(
    .NUM_CH       (3),
    .WIDTH        (8),
    .DEFAULT_DIV  (4),
    .DEFAULT_MODE (1'b0),
    .RESET_EN     (1'b1)
  ) dut (
    .iClk    (iClk),
    .nRst    (nRst),
    .iWr     (iWr),
    .iWrCh   (iWrCh),
    .iWrDiv  (iWrDiv),
    .iWrMode (iWrMode),
    .iWrEn   (iWrEn),
    .iSync   (iSync),
    .oClk    (oClk),
    .oTick   (oTick),
    .oActive (oActive)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] dv, input logic md,
                    input logic en, input logic sy);
    iWr = 1'b1; iWrCh = ch; iWrDiv = dv; iWrMode = md; iWrEn = en; iSync = sy;
    step();
    iWr = 1'b0; iSync = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, held across one posedge
    #12;
    chk("rst_clk", oClk, 3'b000);
    chk("rst_tick", oTick, 3'b000);
    chk("rst_active", oActive, 3'b111);
    nRst = 1'b1;

    // 1: default div 4 toggle; high after edges 4-7, low 8-11, tick every 4th
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("t1_clk_%0d", k), oClk, ((k / 4) % 2 == 1) ? 3'b111 : 3'b000);
      chk($sformatf("t1_tick_%0d", k), oTick, (k % 4 == 0) ? 3'b111 : 3'b000);
    end

    // 2: ch1 pulse div 3, first pulse on 3rd edge after the write
    wr(2'd1, 8'd3, 1'b1, 1'b1, 1'b0);
    chk("t2_load_clk", oClk[1], 1'b0);
    for (int j = 1; j <= 6; j++) begin
      step();
      chk($sformatf("t2_clk_%0d", j), oClk[1], (j % 3 == 0));
      chk($sformatf("t2_tick_%0d", j), oTick[1], (j % 3 == 0));
    end

    // 3: ch2 div 0, then div 1 toggle, then div 1 pulse
    wr(2'd2, 8'd0, 1'b0, 1'b1, 1'b0);
    chk("t3_div0_active", oActive[2], 1'b0);
    for (int j = 1; j <= 3; j++) begin
      step();
      chk($sformatf("t3_div0_out_%0d", j), {oClk[2], oTick[2]}, 2'b00);
    end
    wr(2'd2, 8'd1, 1'b0, 1'b1, 1'b0);
    chk("t3_div1_active", oActive[2], 1'b1);
    chk("t3_div1t_load", oClk[2], 1'b0);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk($sformatf("t3_div1t_clk_%0d", j), oClk[2], (j % 2 == 1));
      chk($sformatf("t3_div1t_tick_%0d", j), oTick[2], 1'b1);
    end
    wr(2'd2, 8'd1, 1'b1, 1'b1, 1'b0);
    for (int j = 1; j <= 3; j++) begin
      step();
      chk($sformatf("t3_div1p_out_%0d", j), {oClk[2], oTick[2]}, 2'b11);
    end

    // 4: ch0 div 5, ch1 div 7, ch2 off; free-run then sync
    wr(2'd0, 8'd5, 1'b0, 1'b1, 1'b0);
    wr(2'd1, 8'd7, 1'b0, 1'b1, 1'b0);
    wr(2'd2, 8'd4, 1'b0, 1'b0, 1'b0);
    chk("t4_active", oActive, 3'b011);
    repeat (10) step();
    iSync = 1'b1;
    step();
    iSync = 1'b0;
    chk("t4_sync_clk", oClk, 3'b000);
    chk("t4_sync_tick", oTick, 3'b000);
    for (int j = 1; j <= 7; j++) begin
      step();
      chk($sformatf("t4_tick_%0d", j), oTick, {1'b0, (j == 7), (j == 5)});
      chk($sformatf("t4_clk_%0d", j), oClk, {1'b0, (j == 7), (j >= 5)});
    end

    // 5a: out-of-range index changes nothing
    wr(2'd3, 8'd2, 1'b1, 1'b0, 1'b0);
    chk("t5_oor_active", oActive, 3'b011);

    // 5b: sync + write ch0 div 2 in the same cycle; ch1 keeps div 7
    wr(2'd0, 8'd2, 1'b0, 1'b1, 1'b1);
    chk("t5_sw_clk", oClk, 3'b000);
    for (int j = 1; j <= 7; j++) begin
      step();
      chk($sformatf("t5_sw_tick_%0d", j), oTick, {1'b0, (j == 7), (j % 2 == 0)});
    end
    chk("t5_pre_rst_clk", oClk, 3'b011);

    // 5c: async reset mid-period, checked before any further edge
    #3;
    nRst = 1'b0;
    #1;
    chk("t5_rst_clk", oClk, 3'b000);
    chk("t5_rst_tick", oTick, 3'b000);
    chk("t5_rst_active", oActive, 3'b111);
    #2;
    nRst = 1'b1;
    step();

    // 6: div 255 toggle, period 510 measured between oClk edges
    wr(2'd0, 8'd255, 1'b0, 1'b1, 1'b0);
    last_rise = 0;
    rises = 0;
    prev_clk = oClk[0];
    chk("t6_load_clk", prev_clk, 1'b0);
    for (int c = 1; c <= 1300; c++) begin
      step();
      cur_clk = oClk[0];
      if (cur_clk && !prev_clk) begin
        if (rises == 0) chk("t6_first_rise", c, 255);
        else chk("t6_period", c - last_rise, 510);
        last_rise = c;
        rises++;
      end else if (!cur_clk && prev_clk) begin
        chk("t6_high", c - last_rise, 255);
      end
      prev_clk = cur_clk;
    end
    chk("t6_rises", rises, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
